// File: rtl/video_sig_gen_if.sv
// Raster timing bundle: position, sync, active-draw and frame outputs from video_sig_gen.
// The master drives every signal. Pixel generation and the TMDS encoders use the slave view.
interface video_sig_gen_if;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hs_out;
  logic        vs_out;
  logic        ad_out;
  logic        nf_out;
  logic [5:0]  fc_out;

  modport master (
    output hcount_out,
    output vcount_out,
    output hs_out,
    output vs_out,
    output ad_out,
    output nf_out,
    output fc_out
  );

  modport slave (
    input hcount_out,
    input vcount_out,
    input hs_out,
    input vs_out,
    input ad_out,
    input nf_out,
    input fc_out
  );
endinterface

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel position, syncs, active-draw, new-frame strobe and frame count.
// All outputs are registered from the next position, so they describe the same pixel with zero skew.
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FPS             = 60
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  video_sig_gen_if.master vid
);
  localparam int TOTAL_PIXELS = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_LINES  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] C_H_LAST     = 11'(TOTAL_PIXELS - 1);
  localparam logic [10:0] C_H_ACTIVE   = 11'(ACTIVE_H_PIXELS);
  localparam logic [10:0] C_HS_START   = 11'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [11:0] C_HS_END     = 12'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [9:0]  C_V_LAST     = 10'(TOTAL_LINES - 1);
  localparam logic [9:0]  C_V_ACTIVE   = 10'(ACTIVE_LINES);
  localparam logic [9:0]  C_VS_START   = 10'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [10:0] C_VS_END     = 11'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [5:0]  C_FC_LAST    = 6'(FPS - 1);

  logic        r_started;
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hs;
  logic        r_vs;
  logic        r_ad;
  logic        r_nf;
  logic [5:0]  r_fc;

  logic [10:0] w_h_next;
  logic [9:0]  w_v_next;
  logic        w_nf_next;

  // Before the first edge after reset the next position is pinned at (0,0) instead of advancing.
  always_comb begin
    w_h_next = '0;
    w_v_next = '0;
    if (r_started) begin
      if (r_hcount == C_H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_vcount == C_V_LAST) ? 10'd0 : r_vcount + 10'd1;
      end else begin
        w_h_next = r_hcount + 11'd1;
        w_v_next = r_vcount;
      end
    end
    w_nf_next = r_started && (w_h_next == C_H_ACTIVE) && (w_v_next == C_V_ACTIVE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_started <= 1'b0;
      r_hcount  <= '0;
      r_vcount  <= '0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_ad      <= 1'b0;
      r_nf      <= 1'b0;
      r_fc      <= '0;
    end else begin
      r_started <= 1'b1;
      r_hcount  <= w_h_next;
      r_vcount  <= w_v_next;
      r_ad      <= (w_h_next < C_H_ACTIVE) && (w_v_next < C_V_ACTIVE);
      r_hs      <= (w_h_next >= C_HS_START) && ({1'b0, w_h_next} < C_HS_END);
      r_vs      <= (w_v_next >= C_VS_START) && ({1'b0, w_v_next} < C_VS_END);
      r_nf      <= w_nf_next;
      if (w_nf_next) begin
        r_fc <= (r_fc == C_FC_LAST) ? 6'd0 : r_fc + 6'd1;
      end
    end
  end

  assign vid.hcount_out = r_hcount;
  assign vid.vcount_out = r_vcount;
  assign vid.hs_out     = r_hs;
  assign vid.vs_out     = r_vs;
  assign vid.ad_out     = r_ad;
  assign vid.nf_out     = r_nf;
  assign vid.fc_out     = r_fc;
endmodule

// File: tb/tb_video_sig_gen.sv
// Scoreboard bench for video_sig_gen with small raster timings: a reference raster model queues
// the expected outputs on each posedge and the checker compares them on the following negedge.
module tb_video_sig_gen;
  localparam int AH  = 8;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 1;
  localparam int AL  = 4;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int FPS_P = 4;
  localparam int TP = AH + HFP + HSW + HBP;
  localparam int TL = AL + VFP + VSW + VBP;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } exp_t;

  logic clk;
  logic rst_n;
  video_sig_gen_if vid_if();

  video_sig_gen #(
    .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .FPS(FPS_P)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .vid(vid_if)
  );

  exp_t sb_q[$];
  int   m_h, m_v, m_fc;
  bit   m_started, m_adv;
  int   pass_cnt, chk_cnt;
  int   nf_seen, nf_exp, cyc;
  exp_t m_e, c_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_h"},  32'(vid_if.hcount_out), 0);
    check_val({tag, "_v"},  32'(vid_if.vcount_out), 0);
    check_val({tag, "_hs"}, 32'(vid_if.hs_out), 0);
    check_val({tag, "_vs"}, 32'(vid_if.vs_out), 0);
    check_val({tag, "_ad"}, 32'(vid_if.ad_out), 0);
    check_val({tag, "_nf"}, 32'(vid_if.nf_out), 0);
    check_val({tag, "_fc"}, 32'(vid_if.fc_out), 0);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference raster model
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_started = 0;
      m_h = 0;
      m_v = 0;
      m_fc = 0;
    end else begin
      m_adv = m_started;
      if (!m_started) begin
        m_h = 0;
        m_v = 0;
        m_started = 1;
      end else if (m_h == TP - 1) begin
        m_h = 0;
        m_v = (m_v == TL - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_e.h  = 11'(m_h);
      m_e.v  = 10'(m_v);
      m_e.ad = (m_h < AH) && (m_v < AL);
      m_e.hs = (m_h >= AH + HFP) && (m_h < AH + HFP + HSW);
      m_e.vs = (m_v >= AL + VFP) && (m_v < AL + VFP + VSW);
      m_e.nf = m_adv && (m_h == AH) && (m_v == AL);
      if (m_e.nf) begin
        m_fc = (m_fc + 1) % FPS_P;
        nf_exp++;
      end
      m_e.fc = 6'(m_fc);
      sb_q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      c_e = sb_q.pop_front();
      check_val("hcount", 32'(vid_if.hcount_out), 32'(c_e.h));
      check_val("vcount", 32'(vid_if.vcount_out), 32'(c_e.v));
      check_val("hs",     32'(vid_if.hs_out),     32'(c_e.hs));
      check_val("vs",     32'(vid_if.vs_out),     32'(c_e.vs));
      check_val("ad",     32'(vid_if.ad_out),     32'(c_e.ad));
      check_val("nf",     32'(vid_if.nf_out),     32'(c_e.nf));
      check_val("fc",     32'(vid_if.fc_out),     32'(c_e.fc));
      if (vid_if.nf_out === 1'b1) begin
        nf_seen++;
        $display("frame strobe at (%0d,%0d) fc=%0d cycle %0d",
                 vid_if.hcount_out, vid_if.vcount_out, vid_if.fc_out, cyc);
      end
    end
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_all_zero("reset");

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("first_h",  32'(vid_if.hcount_out), 0);
    check_val("first_ad", 32'(vid_if.ad_out), 1);
    check_val("first_nf", 32'(vid_if.nf_out), 0);

    // Five frames so fc wraps 3 -> 0 and 1 again
    repeat (TP * TL * 5 + 7) @(negedge clk);

    found = 0;
    for (int i = 0; i < TP * TL * 2 && !found; i++) begin
      @(negedge clk);
      #2;
      if (m_h == 5 && m_v == 2) found = 1;
    end
    check_val("midrst_found", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("midrst_hold");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("restart_h",  32'(vid_if.hcount_out), 0);
    check_val("restart_v",  32'(vid_if.vcount_out), 0);
    check_val("restart_fc", 32'(vid_if.fc_out), 0);

    repeat (TP * TL * 2 + 3) @(negedge clk);
    #1;
    check_val("nf_total", 32'(nf_seen), 32'(nf_exp));
    check_val("nf_total_min", 32'(nf_exp >= 7), 1);
    check_val("sb_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
- Raster timing generator for the HDMI output path. It sits directly upstream of the three per-channel TMDS encoders.
- It produces pixel coordinates, sync pulses, a video-enable (active draw) signal, a new-frame strobe and a frame counter. All are aligned to the same pixel clock edge.
- Downstream consumers wire it as follows:
  - ad_out drives each encoder's video-enable input.
  - {vs_out, hs_out} drives the blue-channel control input.
  - hcount_out/vcount_out drive pixel-generation logic.

Parameters:
- ACTIVE_H_PIXELS, 1280, visible pixels per line
- H_FRONT_PORCH, 110, pixels between end of active and hsync start
- H_SYNC_WIDTH, 40, hsync pulse length in pixels
- H_BACK_PORCH, 220, pixels between hsync end and next line
- ACTIVE_LINES, 720, visible lines per frame
- V_FRONT_PORCH, 5, lines between end of active and vsync start
- V_SYNC_WIDTH, 5, vsync pulse length in lines
- V_BACK_PORCH, 20, lines between vsync end and next frame
- FPS, 60, frame counter modulus

Ports:
- clk_in  input  1  pixel clock (74.25 MHz for 720p60)
- rst_n_in  input  1  asynchronous, active-low reset
- hcount_out  output  11  horizontal position, 0..TOTAL_PIXELS-1
- vcount_out  output  10  vertical position, 0..TOTAL_LINES-1
- hs_out  output  1  horizontal sync, active-high
- vs_out  output  1  vertical sync, active-high
- ad_out  output  1  active draw: high when the current position is inside the visible area
- nf_out  output  1  single-cycle new-frame strobe
- fc_out  output  6  frame count, 0..FPS-1

Behaviour:
- Derived constants:
  - TOTAL_PIXELS = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH = 1650 at default.
  - TOTAL_LINES = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH = 750 at default.
- Reset:
  - rst_n_in low forces all outputs to 0 immediately (asynchronous), including ad_out.
  - Reset asserted mid-frame abandons the frame. No partial state survives.
- First position after reset:
  - The first posedge after rst_n_in rises presents position (0,0): hcount_out=0, vcount_out=0, ad_out=1, hs_out=0, vs_out=0.
  - An internal "started" flag distinguishes this edge from normal advancing.
- Advancing, on every later posedge:
  - hcount_out increments by 1.
  - At TOTAL_PIXELS-1, hcount_out wraps to 0 and vcount_out increments.
  - When vcount_out is TOTAL_LINES-1 and hcount_out wraps, vcount_out wraps to 0.
- Output alignment:
  - All outputs are registered and describe the same position in the same cycle. hs_out, vs_out and ad_out have zero skew relative to the counts.
- ad_out = (hcount < ACTIVE_H_PIXELS) && (vcount < ACTIVE_LINES).
- hs_out is high for hcount in [ACTIVE_H_PIXELS+H_FRONT_PORCH, ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH), i.e. [1390,1430) at default.
  - This applies on every line, including blanking lines.
- vs_out is high for the whole of any line whose vcount is in [ACTIVE_LINES+V_FRONT_PORCH, ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH), i.e. [725,730). It spans all hcount values of those lines.
- nf_out:
  - High for exactly one cycle, when the position is (hcount=ACTIVE_H_PIXELS, vcount=ACTIVE_LINES), i.e. (1280,720).
  - It is never asserted during the post-reset (0,0) presentation.
- fc_out:
  - Increments in the same cycle nf_out is high, so the new value is visible together with nf_out.
  - Wraps FPS-1 → 0.
- Width rules:
  - Count widths are fixed at 11/10/6 bits. Parameters must yield TOTAL_PIXELS ≤ 2048, TOTAL_LINES ≤ 1024 and FPS ≤ 64.
  - All comparisons are unsigned.
- No other outputs glitch. Every output changes only on posedge clk_in or on reset assertion.

Test Plan:
1. Reset and first pixel: hold rst_n_in low 10 cycles → all outputs 0. Release it → next edge shows hcount=0, vcount=0, ad=1, hs=0, vs=0, nf=0, fc=0.
2. Horizontal timing on line 0:
   - ad falls when hcount goes 1279→1280.
   - hs rises at hcount=1390 and falls at 1430 (40 cycles high).
   - hcount 1649 → 0 with vcount 0→1.
3. Vertical timing:
   - ad stays 0 on all of line 720.
   - vs rises at (0,725) and falls at (0,730) (5×1650 cycles high).
   - vcount 749 → 0 at the frame wrap.
4. Frame strobe: nf pulses exactly once per 1,237,500 cycles, at (1280,720), with fc 0→1 in that same cycle.
5. Counter wrap: with FPS=4 and small test timings (e.g. 8×4 active, porches 1/2/1), fc cycles 0,1,2,3,0. All sync widths match the parameters.
6. Mid-frame reset: assert rst_n_in asynchronously at (700,400) → outputs 0 before the next edge. After release, timing restarts at (0,0) with fc=0.
